// File: rtl/mem_port_arb.sv
// Two-requester arbiter for the external memory port.
// Fetch and load/store share one registered req/ack bus with timeout.
module mem_port_arb #(
    parameter int MAX_D_RUN   = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_en_i,
    input  logic        d_wr_i,
    input  logic [1:0]  d_wscope_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [1:0]  bus_wscope_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        err_o
);

    localparam int RUN_W = $clog2(MAX_D_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [CNT_W-1:0] tmo_cnt;

    logic run_full;
    logic grant_d;
    logic grant_i;
    logic tmo_hit;
    logic finish;

    // Fetch wins a tie only once data has had MAX_D_RUN grants in a row.
    assign run_full = (run_cnt == RUN_MAX);
    assign grant_d  = d_en_i && !(if_req_i && run_full);
    assign grant_i  = if_req_i && !grant_d;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign finish   = bus_ack_i || tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            run_cnt      <= '0;
            tmo_cnt      <= '0;
            if_done_o    <= 1'b0;
            if_rdata_o   <= '0;
            d_done_o     <= 1'b0;
            d_rdata_o    <= '0;
            bus_req_o    <= 1'b0;
            bus_wr_o     <= 1'b0;
            bus_wscope_o <= 2'b00;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            if_done_o <= 1'b0;
            d_done_o  <= 1'b0;
            err_o     <= 1'b0;
            unique case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    unique case (1'b1)
                        grant_d: begin
                            state        <= BUSY_D;
                            bus_req_o    <= 1'b1;
                            bus_wr_o     <= d_wr_i;
                            bus_wscope_o <= d_wr_i ? d_wscope_i : 2'b11;
                            bus_addr_o   <= d_addr_i;
                            bus_wdata_o  <= d_wr_i ? d_wdata_i : '0;
                            if (!if_req_i)
                                run_cnt <= '0;
                            else if (!run_full)
                                run_cnt <= run_cnt + 1'b1;
                        end
                        grant_i: begin
                            state        <= BUSY_I;
                            bus_req_o    <= 1'b1;
                            bus_wr_o     <= 1'b0;
                            bus_wscope_o <= 2'b11;
                            bus_addr_o   <= if_addr_i;
                            bus_wdata_o  <= '0;
                            run_cnt      <= '0;
                        end
                        default: ;
                    endcase
                end
                BUSY_I, BUSY_D: begin
                    if (finish) begin
                        state     <= IDLE;
                        bus_req_o <= 1'b0;
                        err_o     <= !bus_ack_i;
                        if (state == BUSY_I) begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
                        end else begin
                            d_done_o  <= 1'b1;
                            d_rdata_o <= (bus_ack_i && !bus_wr_o) ?
                                         bus_rdata_i : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        d_en;
    logic        d_wr;
    logic [1:0]  d_wscope;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done_o;
    logic [31:0] d_rdata_o;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [1:0]  bus_wscope_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arb #(
        .MAX_D_RUN(4),
        .TIMEOUT_CYC(255),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req_i(if_req),
        .if_addr_i(if_addr),
        .if_done_o(if_done_o),
        .if_rdata_o(if_rdata_o),
        .d_en_i(d_en),
        .d_wr_i(d_wr),
        .d_wscope_i(d_wscope),
        .d_addr_i(d_addr),
        .d_wdata_i(d_wdata),
        .d_done_o(d_done_o),
        .d_rdata_o(d_rdata_o),
        .bus_req_o(bus_req_o),
        .bus_wr_o(bus_wr_o),
        .bus_wscope_o(bus_wscope_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack),
        .bus_rdata_i(bus_rdata),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        bit exp_d [6];
        int s;
        int cnt;
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        d_en = 1'b0;
        d_wr = 1'b0;
        d_wscope = 2'b00;
        d_addr = '0;
        d_wdata = '0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        tick;
        tick;
        chk("rst_req", bus_req_o, 0);
        chk("rst_idone", if_done_o, 0);
        chk("rst_ddone", d_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_irdata", if_rdata_o, 0);
        chk("rst_drdata", d_rdata_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        rst_n = 1'b1;
        tick;

        // fetch only, ack two cycles after request
        if_req = 1'b1;
        if_addr = 32'h100;
        tick;
        chk("t1_req", bus_req_o, 1);
        chk("t1_wr", bus_wr_o, 0);
        chk("t1_scope", bus_wscope_o, 2'b11);
        chk("t1_addr", bus_addr_o, 32'h100);
        chk("t1_wdata", bus_wdata_o, 0);
        tick;
        chk("t1_hold", bus_req_o, 1);
        chk("t1_nodone", if_done_o, 0);
        tick;
        bus_ack = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        tick;
        bus_ack = 1'b0;
        if_req = 1'b0;
        chk("t1_done", if_done_o, 1);
        chk("t1_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("t1_reqdrop", bus_req_o, 0);
        tick;
        chk("t1_pulse", if_done_o, 0);
        chk("t1_idle", bus_req_o, 0);

        // stray ack while idle
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        tick;
        bus_ack = 1'b0;
        chk("idle_ack_idone", if_done_o, 0);
        chk("idle_ack_ddone", d_done_o, 0);
        chk("idle_ack_rdata", if_rdata_o, 32'hDEADBEEF);

        // fetch and load together
        if_req = 1'b1;
        if_addr = 32'h200;
        d_en = 1'b1;
        d_wr = 1'b0;
        d_wscope = 2'b00;
        d_addr = 32'h2004;
        d_wdata = 32'h55;
        tick;
        chk("t2_req", bus_req_o, 1);
        chk("t2_addr", bus_addr_o, 32'h2004);
        chk("t2_scope", bus_wscope_o, 2'b11);
        chk("t2_wdata", bus_wdata_o, 0);
        bus_ack = 1'b1;
        bus_rdata = 32'h12345678;
        tick;
        bus_ack = 1'b0;
        d_en = 1'b0;
        chk("t2_ddone", d_done_o, 1);
        chk("t2_idone0", if_done_o, 0);
        chk("t2_drdata", d_rdata_o, 32'h12345678);
        chk("t2_gap", bus_req_o, 0);
        tick;
        chk("t2_ireq", bus_req_o, 1);
        chk("t2_iaddr", bus_addr_o, 32'h200);
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        tick;
        bus_ack = 1'b0;
        if_req = 1'b0;
        chk("t2_idone", if_done_o, 1);
        chk("t2_irdata", if_rdata_o, 32'hCAFEF00D);
        chk("t2_dkeep", d_rdata_o, 32'h12345678);

        // fetch held, five back-to-back stores
        if_req = 1'b1;
        if_addr = 32'h300;
        d_en = 1'b1;
        d_wr = 1'b1;
        d_wscope = 2'b11;
        s = 0;
        d_addr = 32'h4000;
        d_wdata = 32'h1000;
        for (int g = 0; g < 6; g++) begin
            tick;
            chk("t3_req", bus_req_o, 1);
            chk("t3_addr", bus_addr_o,
                exp_d[g] ? 32'h4000 + 32'(4 * s) : 32'h300);
            chk("t3_wr", bus_wr_o, exp_d[g]);
            bus_ack = 1'b1;
            bus_rdata = 32'hA0 + 32'(g);
            tick;
            bus_ack = 1'b0;
            chk("t3_ddone", d_done_o, exp_d[g]);
            chk("t3_idone", if_done_o, !exp_d[g]);
            if (exp_d[g]) begin
                chk("t3_drdata", d_rdata_o, 0);
                s++;
                d_addr = 32'h4000 + 32'(4 * s);
                d_wdata = 32'h1000 + 32'(s);
                if (s == 5)
                    d_en = 1'b0;
            end else begin
                chk("t3_irdata", if_rdata_o, 32'hA0 + 32'(g));
                if_req = 1'b0;
            end
        end
        tick;
        chk("t3_idle", bus_req_o, 0);

        // load to leave nonzero data before the timeout
        d_en = 1'b1;
        d_wr = 1'b0;
        d_addr = 32'h10;
        tick;
        chk("ld_req", bus_req_o, 1);
        bus_ack = 1'b1;
        bus_rdata = 32'h0BAD0001;
        tick;
        bus_ack = 1'b0;
        d_en = 1'b0;
        chk("ld_done", d_done_o, 1);
        chk("ld_rdata", d_rdata_o, 32'h0BAD0001);

        // byte store never acked
        d_en = 1'b1;
        d_wr = 1'b1;
        d_wscope = 2'b00;
        d_addr = 32'h3;
        d_wdata = 32'hAB;
        tick;
        chk("t4_req", bus_req_o, 1);
        chk("t4_wr", bus_wr_o, 1);
        chk("t4_scope", bus_wscope_o, 2'b00);
        chk("t4_wdata", bus_wdata_o, 32'hAB);
        chk("t4_addr", bus_addr_o, 32'h3);
        d_addr = 32'hFFFFFFF0;
        d_wdata = 32'h0;
        tick;
        chk("t4_stable_addr", bus_addr_o, 32'h3);
        chk("t4_stable_wdata", bus_wdata_o, 32'hAB);
        cnt = 1;
        while (bus_req_o === 1'b1 && cnt < 400) begin
            cnt++;
            tick;
        end
        chk("t4_len", 32'(cnt), 32'd255);
        chk("t4_err", err_o, 1);
        chk("t4_ddone", d_done_o, 1);
        chk("t4_drdata", d_rdata_o, 0);
        d_en = 1'b0;
        tick;
        chk("t4_err_pulse", err_o, 0);
        chk("t4_done_pulse", d_done_o, 0);
        chk("t4_idle", bus_req_o, 0);

        // ack on the last cycle before timeout
        if_req = 1'b1;
        if_addr = 32'h600;
        tick;
        chk("t5_req", bus_req_o, 1);
        cnt = 1;
        while (cnt < 255) begin
            tick;
            cnt++;
        end
        chk("t5_req_last", bus_req_o, 1);
        bus_ack = 1'b1;
        bus_rdata = 32'h5A5A5A5A;
        tick;
        bus_ack = 1'b0;
        if_req = 1'b0;
        chk("t5_idone", if_done_o, 1);
        chk("t5_noerr", err_o, 0);
        chk("t5_irdata", if_rdata_o, 32'h5A5A5A5A);
        chk("t5_reqdrop", bus_req_o, 0);

        // reset in the middle of a load
        d_en = 1'b1;
        d_wr = 1'b0;
        d_addr = 32'h40;
        tick;
        chk("t6_req", bus_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", bus_req_o, 0);
        d_en = 1'b0;
        tick;
        chk("t6_nodone", d_done_o, 0);
        chk("t6_irdata_clr", if_rdata_o, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("t6_idle", bus_req_o, 0);
        chk("t6_nodone2", d_done_o, 0);
        if_req = 1'b1;
        if_addr = 32'h500;
        tick;
        chk("t6_req2", bus_req_o, 1);
        chk("t6_addr2", bus_addr_o, 32'h500);
        bus_ack = 1'b1;
        bus_rdata = 32'h0000600D;
        tick;
        bus_ack = 1'b0;
        if_req = 1'b0;
        chk("t6_idone", if_done_o, 1);
        chk("t6_irdata", if_rdata_o, 32'h0000600D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
